// File: rtl/dvsd_pe_pkg.sv
// Shared definitions for the dvsd priority-encoder family: mode encodings
// and the mod-N pointer increment used by the round-robin search.
package dvsd_pe_pkg;

  localparam logic PE_MODE_FIXED = 1'b0;
  localparam logic PE_MODE_RR    = 1'b1;

  // (idx + 1) mod n for idx < n; idx = n-1 wraps to 0 even when n is not a power of two
  function automatic int unsigned pe_wrap_inc(input int unsigned idx, input int unsigned n);
    int unsigned nxt;
    nxt = idx + 32'd1;
    if (nxt >= n) begin
      nxt = 32'd0;
    end else begin
      nxt = nxt;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/dvsd_pe_fixed.sv
// Combinational lowest-index-first priority encoder: index, one-hot and any-set
// of the lowest set bit of req_i.
module dvsd_pe_fixed #(
  parameter int N = 8,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] req_i,
  output logic [W-1:0] idx_o,
  output logic [N-1:0] onehot_o,
  output logic         any_o
);

  localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

  // Scan from the top down so the lowest set bit is the last one written
  always_comb begin
    idx_o    = '0;
    onehot_o = '0;
    any_o    = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      idx_o    = req_i[i] ? W'(i)      : idx_o;
      onehot_o = req_i[i] ? (ONE << i) : onehot_o;
      any_o    = req_i[i] ? 1'b1       : any_o;
    end
  end

endmodule

// File: rtl/dvsd_pe_rr.sv
// Registered N-input priority encoder with fixed / round-robin modes and
// valid/ready handshakes; keeps the gs/eno cascade outputs.
module dvsd_pe_rr
  import dvsd_pe_pkg::*;
#(
  parameter int N = 8,
  parameter int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         mode,
  input  logic [N-1:0] req,
  input  logic         req_valid,
  output logic         req_ready,
  output logic [W-1:0] out,
  output logic [N-1:0] out_onehot,
  output logic         gs,
  output logic         eno,
  output logic         out_valid,
  input  logic         out_ready
);

  logic [W-1:0] out_q, out_d;
  logic [N-1:0] onehot_q, onehot_d;
  logic         gs_q, gs_d;
  logic         eno_q, eno_d;
  logic         valid_q, valid_d;
  logic [W-1:0] ptr_q, ptr_d;

  logic [N-1:0] mask_s;
  logic [W-1:0] m_idx_s, f_idx_s, win_idx_s;
  logic [N-1:0] m_oh_s, f_oh_s, win_oh_s;
  logic         m_any_s, f_any_s, win_any_s;
  logic         acc_s;

  // Keep only the requests at or above the round-robin pointer
  always_comb begin
    mask_s = '0;
    for (int i = 0; i < N; i++) begin
      mask_s[i] = (i >= int'(ptr_q)) ? 1'b1 : 1'b0;
    end
  end

  dvsd_pe_fixed #(.N(N), .W(W)) u_masked (
    .req_i    (req & mask_s),
    .idx_o    (m_idx_s),
    .onehot_o (m_oh_s),
    .any_o    (m_any_s)
  );

  dvsd_pe_fixed #(.N(N), .W(W)) u_full (
    .req_i    (req),
    .idx_o    (f_idx_s),
    .onehot_o (f_oh_s),
    .any_o    (f_any_s)
  );

  // Masked hit wins in round-robin; otherwise the search wraps to the unmasked result
  always_comb begin
    if ((mode == PE_MODE_RR) && m_any_s) begin
      win_idx_s = m_idx_s;
      win_oh_s  = m_oh_s;
    end else begin
      win_idx_s = f_idx_s;
      win_oh_s  = f_oh_s;
    end
    win_any_s = f_any_s;
  end

  assign req_ready = en & (~valid_q | out_ready);
  assign acc_s     = req_valid & req_ready;

  // Next-state for the result registers, valid flag and pointer
  always_comb begin
    out_d    = out_q;
    onehot_d = onehot_q;
    gs_d     = gs_q;
    eno_d    = eno_q;
    valid_d  = valid_q;
    ptr_d    = ptr_q;
    if (acc_s) begin
      valid_d = 1'b1;
      if (win_any_s) begin
        out_d    = win_idx_s;
        onehot_d = win_oh_s;
        gs_d     = 1'b1;
        eno_d    = 1'b0;
        if (mode == PE_MODE_RR) begin
          ptr_d = W'(pe_wrap_inc(32'(win_idx_s), N));
        end else begin
          ptr_d = ptr_q;
        end
      end else begin
        out_d    = '0;
        onehot_d = '0;
        gs_d     = 1'b0;
        eno_d    = 1'b1;
      end
    end else if (out_ready) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  // State registers; reset discards any pending result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q    <= '0;
      onehot_q <= '0;
      gs_q     <= 1'b0;
      eno_q    <= 1'b0;
      valid_q  <= 1'b0;
      ptr_q    <= '0;
    end else begin
      out_q    <= out_d;
      onehot_q <= onehot_d;
      gs_q     <= gs_d;
      eno_q    <= eno_d;
      valid_q  <= valid_d;
      ptr_q    <= ptr_d;
    end
  end

  assign out        = out_q;
  assign out_onehot = onehot_q;
  assign gs         = gs_q;
  assign eno        = eno_q;
  assign out_valid  = valid_q;

endmodule

// File: tb/tb_dvsd_pe_rr.sv
// Directed self-checking bench for dvsd_pe_rr: an N=8 instance for the main
// scenarios and an N=5 instance for the non-power-of-two round-robin wrap.
module tb_dvsd_pe_rr;

  logic       clk;
  logic       rst_n;

  logic       a_en, a_mode, a_req_valid, a_req_ready, a_out_ready;
  logic [7:0] a_req, a_onehot;
  logic [2:0] a_out;
  logic       a_gs, a_eno, a_out_valid;

  logic       b_en, b_mode, b_req_valid, b_req_ready, b_out_ready;
  logic [4:0] b_req, b_onehot;
  logic [2:0] b_out;
  logic       b_gs, b_eno, b_out_valid;

  int chk_cnt;
  int pass_cnt;

  dvsd_pe_rr #(.N(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .en(a_en), .mode(a_mode), .req(a_req),
    .req_valid(a_req_valid), .req_ready(a_req_ready), .out(a_out),
    .out_onehot(a_onehot), .gs(a_gs), .eno(a_eno), .out_valid(a_out_valid),
    .out_ready(a_out_ready)
  );

  dvsd_pe_rr #(.N(5)) u_dut5 (
    .clk(clk), .rst_n(rst_n), .en(b_en), .mode(b_mode), .req(b_req),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .out(b_out),
    .out_onehot(b_onehot), .gs(b_gs), .eno(b_eno), .out_valid(b_out_valid),
    .out_ready(b_out_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    if (obs === exp) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    chk_cnt  = 0;
    pass_cnt = 0;
    rst_n = 1'b0;
    a_en = 1'b0; a_mode = 1'b0; a_req = 8'h00; a_req_valid = 1'b0; a_out_ready = 1'b0;
    b_en = 1'b0; b_mode = 1'b0; b_req = 5'h00; b_req_valid = 1'b0; b_out_ready = 1'b0;

    // Reset state
    #12;
    check("rst_valid",  32'(a_out_valid), 32'd0);
    check("rst_out",    32'(a_out), 32'd0);
    check("rst_onehot", 32'(a_onehot), 32'd0);
    check("rst_gs",     32'(a_gs), 32'd0);
    check("rst_eno",    32'(a_eno), 32'd0);
    check("rst_ptr",    32'(u_dut8.ptr_q), 32'd0);
    check("rst_b_valid", 32'(b_out_valid), 32'd0);
    #5 rst_n = 1'b1;
    tick();

    // Fixed mode: lowest set bit of 1010_0100 is index 2
    a_en = 1'b1; a_mode = 1'b0; a_req = 8'b1010_0100; a_req_valid = 1'b1; a_out_ready = 1'b1;
    #1;
    check("fx_req_ready", 32'(a_req_ready), 32'd1);
    tick();
    a_req_valid = 1'b0;
    check("fx_out",    32'(a_out), 32'd2);
    check("fx_onehot", 32'(a_onehot), 32'h04);
    check("fx_gs",     32'(a_gs), 32'd1);
    check("fx_eno",    32'(a_eno), 32'd0);
    check("fx_valid",  32'(a_out_valid), 32'd1);
    check("fx_ptr",    32'(u_dut8.ptr_q), 32'd0);
    tick();
    check("fx_drain_valid", 32'(a_out_valid), 32'd0);

    // Round-robin over all-ones: 0..7 then 0,1; pointer ends at 2
    a_mode = 1'b1; a_req = 8'hFF; a_req_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check($sformatf("rr8_out%0d", i), 32'(a_out), 32'(i % 8));
      check($sformatf("rr8_oh%0d", i), 32'(a_onehot), 32'd1 << (i % 8));
      check($sformatf("rr8_valid%0d", i), 32'(a_out_valid), 32'd1);
    end
    check("rr8_ptr", 32'(u_dut8.ptr_q), 32'd2);

    // All-zero request: eno result, pointer untouched
    a_req = 8'h00;
    tick();
    check("z_gs",     32'(a_gs), 32'd0);
    check("z_eno",    32'(a_eno), 32'd1);
    check("z_out",    32'(a_out), 32'd0);
    check("z_onehot", 32'(a_onehot), 32'd0);
    check("z_valid",  32'(a_out_valid), 32'd1);
    check("z_ptr",    32'(u_dut8.ptr_q), 32'd2);

    // Backpressure for three cycles: nothing accepted, outputs frozen
    a_out_ready = 1'b0; a_req = 8'h10;
    for (int i = 0; i < 3; i++) begin
      #1;
      check($sformatf("bp_ready%0d", i), 32'(a_req_ready), 32'd0);
      tick();
      check($sformatf("bp_eno%0d", i), 32'(a_eno), 32'd1);
      check($sformatf("bp_gs%0d", i), 32'(a_gs), 32'd0);
      check($sformatf("bp_valid%0d", i), 32'(a_out_valid), 32'd1);
      check($sformatf("bp_ptr%0d", i), 32'(u_dut8.ptr_q), 32'd2);
    end

    // Release with a new vector: back-to-back load, ptr=2 picks bit 4
    a_out_ready = 1'b1;
    #1;
    check("b2b_ready", 32'(a_req_ready), 32'd1);
    tick();
    check("b2b_out",   32'(a_out), 32'd4);
    check("b2b_gs",    32'(a_gs), 32'd1);
    check("b2b_valid", 32'(a_out_valid), 32'd1);
    check("b2b_ptr",   32'(u_dut8.ptr_q), 32'd5);
    // ptr=5 sees nothing at/above 5 in 8'h03, wraps to bit 0
    a_req = 8'h03;
    tick();
    check("wrap_out",   32'(a_out), 32'd0);
    check("wrap_valid", 32'(a_out_valid), 32'd1);
    check("wrap_ptr",   32'(u_dut8.ptr_q), 32'd1);

    // en=0: pending result drains, no new accepts, ptr holds
    a_en = 1'b0; a_req = 8'hFF;
    #1;
    check("en0_ready", 32'(a_req_ready), 32'd0);
    tick();
    check("en0_drain", 32'(a_out_valid), 32'd0);
    check("en0_hold_out", 32'(a_onehot), 32'h01);
    check("en0_ptr",   32'(u_dut8.ptr_q), 32'd1);
    tick();
    check("en0_ready2", 32'(a_req_ready), 32'd0);
    check("en0_valid2", 32'(a_out_valid), 32'd0);
    check("en0_ptr2",  32'(u_dut8.ptr_q), 32'd1);

    // Asynchronous reset mid-stream
    a_en = 1'b1;
    tick();
    check("pre_rst_out", 32'(a_out), 32'd1);
    check("pre_rst_ptr", 32'(u_dut8.ptr_q), 32'd2);
    a_req_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid",  32'(a_out_valid), 32'd0);
    check("arst_out",    32'(a_out), 32'd0);
    check("arst_onehot", 32'(a_onehot), 32'd0);
    check("arst_gs",     32'(a_gs), 32'd0);
    check("arst_eno",    32'(a_eno), 32'd0);
    check("arst_ptr",    32'(u_dut8.ptr_q), 32'd0);
    #2 rst_n = 1'b1;
    tick();

    // N=5 round-robin on 10001: 0,4,0,4 with wrap from 4 back to 0
    b_en = 1'b1; b_mode = 1'b1; b_req = 5'b10001; b_req_valid = 1'b1; b_out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("rr5_out%0d", i), 32'(b_out), (i % 2 == 0) ? 32'd0 : 32'd4);
      check($sformatf("rr5_oh%0d", i), 32'(b_onehot), (i % 2 == 0) ? 32'h01 : 32'h10);
      check($sformatf("rr5_ptr%0d", i), 32'(u_dut5.ptr_q), (i % 2 == 0) ? 32'd1 : 32'd0);
    end
    b_req_valid = 1'b0;
    tick();

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/dvsd_pe_rr.md
# dvsd_pe_rr

Parametrised, registered priority encoder with a runtime-selectable fixed-priority or round-robin mode and valid/ready handshakes on both sides. It extends the 8-input encoder to N inputs and keeps the cascade outputs `gs` and `eno`. It sits between request-collecting logic and a downstream consumer, such as an arbiter grant path or an interrupt vector unit, and accepts one request vector per cycle at full throughput.

## Interface
- `N`, default 8: number of request lines; N ≥ 2, need not be a power of two.
- `W`, default `$clog2(N)`: index width; derived, not overridden.
- `clk`  in  1  sole clock; all state updates on posedge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `en`  in  1  block enable; 0 stalls input acceptance.
- `mode`  in  1  0 = fixed priority (bit 0 highest), 1 = round-robin.
- `req`  in  N  request vector.
- `req_valid`  in  1  `req` and `mode` are valid.
- `req_ready`  out  1  block can accept this cycle.
- `out`  out  W  encoded index of the winning request.
- `out_onehot`  out  N  one-hot of the winner; all-zero if no request.
- `gs`  out  1  group select: 1 when the accepted vector had ≥1 bit set.
- `eno`  out  1  enable-out for cascading: 1 when the accepted vector was all-zero.
- `out_valid`  out  1  output registers hold a result.
- `out_ready`  in  1  consumer takes the result.

## Operation
- Accept: `acc = req_valid & req_ready`.
- `req_ready = en & (~out_valid | out_ready)`. It is combinational and must not depend on `req_valid`.
- Fixed mode: winner is the lowest set index of `req`.
- Round-robin mode: search starts at pointer `ptr` (W bits, reset 0) and proceeds ptr, ptr+1, …, N-1, 0, …, ptr-1. The winner is the first set bit.
- On `acc` with a nonzero `req`:
  - `out` = winner; `out_onehot` = 1<<winner; `gs` = 1; `eno` = 0.
  - Only in round-robin mode, `ptr <= (winner+1) mod N`; wrap from N-1 goes to 0 for any N.
- On `acc` with `req` all-zero:
  - `out` = 0; `out_onehot` = 0; `gs` = 0; `eno` = 1; `ptr` unchanged.
- Fixed-mode accepts never modify `ptr`. A later switch to round-robin resumes from the retained `ptr`.
- `mode` is sampled only on `acc`. Mode changes while idle have no effect.
- `ptr` values ≥ N are unreachable; they need no handling beyond the mod-N wrap.

## Timing
- Latency: one cycle. If `acc` occurs at edge k, results and `out_valid=1` are visible after edge k.
- Throughput: one vector per cycle while `out_ready=1` and `en=1`.
- Output hold:
  - `out_valid` clears on `out_ready & ~acc`.
  - When `out_ready & acc` occur together, the registers load the new result and `out_valid` stays 1.
  - While `out_valid & ~out_ready`, all outputs hold stable and `req_ready=0`.
- `en` = 0:
  - No new accepts.
  - A pending result still drains when `out_ready=1`.
  - Output registers and `ptr` otherwise hold.
- Reset, asynchronous, effective immediately, including mid-transfer:
  - `out_valid`=0, `out`=0, `out_onehot`=0, `gs`=0, `eno`=0, `ptr`=0.
  - A result pending at reset is discarded.
- No combinational path from `req`/`req_valid` to any output except none; `req_ready` depends only on `en`, `out_valid` and `out_ready`.

## Structure
- Shared package `dvsd_pe_pkg`:
  - mode encodings `PE_MODE_FIXED=1'b0` and `PE_MODE_RR=1'b1`;
  - a function for wrap-increment mod N.
- Sub-module `dvsd_pe_fixed #(N)`: purely combinational lowest-index-first encoder producing index, one-hot and any-set.
- Round-robin mode is built around `dvsd_pe_fixed`:
  - instantiate it twice, once on `req & mask(ptr)` (bits ≥ ptr) and once on the unmasked `req`;
  - take the masked result if its any-set is 1, else the unmasked result.
- Top level holds only the output registers, `ptr` and the handshake logic.

## Test plan
- N=8, fixed mode, `req`=8'b1010_0100, `out_ready`=1 → next cycle `out`=2, `out_onehot`=8'h04, `gs`=1, `eno`=0, `out_valid`=1.
- N=8, round-robin, `req`=8'hFF held for 10 accepts → `out` sequence 0,1,…,7,0,1; `ptr` returns to 2.
- N=5, round-robin, `req`=5'b10001 repeated → `out` alternates 0,4,0,4; the wrap from 4 to 0 is exercised with a non-power-of-two N.
- `req`=0 accepted → `gs`=0, `eno`=1, `out`=0, `ptr` unchanged. Then with `out_ready`=0 for 3 cycles:
  - `req_ready`=0;
  - outputs stable;
  - releasing `out_ready` with a new `req_valid` gives a back-to-back update and `out_valid` stays 1.
- `en`=0 with a pending result → that result drains, then `req_ready` stays 0 and `ptr` holds. Asserting `rst_n`=0 mid-stream → all outputs and `ptr` go to 0 asynchronously, before the next clock edge.
